instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 127 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: IDLE/REQ/ISSUE/HALT sequencer with next-PC selection.
// Optional misaligned-target trap enabled by defining IFETCH_MISALIGN_EN.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jr,
  input  logic        jmp,
  input  logic        jal,
  input  logic        branch,
  input  logic        nbranch,
  input  logic        zero,
  input  logic [31:0] imm32,
  input  logic [31:0] rs_data,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] link_addr,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, REQ, ISSUE, HALT} state_t;

  state_t      state;
  logic        taken;
  logic [31:0] npc_raw;

  // Word offset is a signed count of instructions; wraps modulo 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                input logic signed [31:0] offset);
    logic signed [31:0] byte_ofs;
    byte_ofs = offset <<< 2;
    return base + unsigned'(byte_ofs);
  endfunction

  assign op        = instr[31:26];
  assign func      = instr[5:0];
  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  assign taken = (branch & zero) | (nbranch & ~zero);

  always_comb begin
    npc_raw = pc_plus4;
    if (jr)
      npc_raw = rs_data;
    else if (jmp || jal)
      npc_raw = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (taken)
      npc_raw = branch_target(pc_plus4, signed'(imm32));
  end

`ifndef IFETCH_MISALIGN_EN
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      link_addr   <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
`ifdef IFETCH_MISALIGN_EN
      misalign    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            state       <= ISSUE;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        ISSUE: begin
          // Redirect inputs are only meaningful on the cycle the instruction leaves.
          if (!stall) begin
            instr_valid <= 1'b0;
            if (jal)
              link_addr <= pc_plus4;
`ifdef IFETCH_MISALIGN_EN
            pc <= npc_raw;
            if (|npc_raw[1:0]) begin
              misalign <= 1'b1;
              state    <= HALT;
            end else begin
              state    <= REQ;
              imem_req <= 1'b1;
            end
`else
            pc       <= align_word(npc_raw);
            state    <= REQ;
            imem_req <= 1'b1;
`endif
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
